// File: rtl/comparator_2bit.sv
// Registered magnitude comparator with one-hot less/equal/greater flags and 1-cycle latency.
// Optional saturating per-result event counters are enabled by defining COMPARATOR_STATS_EN.
module comparator_2bit #(
  parameter int WIDTH      = 2,
  parameter int SIGNED_CMP = 0,
  parameter int CNT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             less,
  output logic             equal,
  output logic             greater
`ifdef COMPARATOR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_less,
  output logic [CNT_W-1:0] cnt_equal,
  output logic [CNT_W-1:0] cnt_greater
`endif
);

  // Flipping the sign bit maps two's complement onto offset binary, so one
  // unsigned compare serves both modes.
  localparam logic [WIDTH-1:0] MSB_MASK = (SIGNED_CMP != 0) ?
                                          (WIDTH'(1'b1) << (WIDTH - 1)) : WIDTH'(1'b0);

  function automatic logic is_less(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x ^ MSB_MASK) < (y ^ MSB_MASK);
  endfunction

  logic less_s;
  logic equal_s;
  logic greater_s;

  // Combinational compare of the current operands
  always_comb begin
    less_s    = 1'b0;
    equal_s   = 1'b0;
    greater_s = 1'b0;
    if (a == b) begin
      equal_s = 1'b1;
    end else if (is_less(a, b)) begin
      less_s = 1'b1;
    end else begin
      greater_s = 1'b1;
    end
  end

  // Result register; flags hold their last value while in_valid is low
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_valid <= 1'b0;
      less      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      less      <= less_s;
      equal     <= equal_s;
      greater   <= greater_s;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return c;
    end else begin
      return c + CNT_W'(1'b1);
    end
  endfunction

  // Event counters; a clear in the same cycle as a valid sample drops that sample
  always_ff @(posedge sys_clk) begin
    if (sys_rst || stats_clr) begin
      cnt_less    <= '0;
      cnt_equal   <= '0;
      cnt_greater <= '0;
    end else if (in_valid) begin
      if (less_s) begin
        cnt_less <= sat_inc(cnt_less);
      end else if (equal_s) begin
        cnt_equal <= sat_inc(cnt_equal);
      end else begin
        cnt_greater <= sat_inc(cnt_greater);
      end
    end else begin
      cnt_less    <= cnt_less;
      cnt_equal   <= cnt_equal;
      cnt_greater <= cnt_greater;
    end
  end
`endif

endmodule

// File: tb/tb_comparator_2bit.sv
// Directed self-checking bench for comparator_2bit: an unsigned and a signed instance
// share the stimulus; the counter checks run only when COMPARATOR_STATS_EN is defined.
module tb_comparator_2bit;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] a = 2'b00;
  logic [1:0] b = 2'b00;
  logic       ov_u, lt_u, eq_u, gt_u;
  logic       ov_s, lt_s, eq_s, gt_s;
  int         n_vec = 0;
  int         n_err = 0;

`ifdef COMPARATOR_STATS_EN
  logic       stats_clr = 1'b0;
  logic [1:0] cl_u, ce_u, cg_u;
  logic [1:0] cl_s, ce_s, cg_s;
`endif

  always #5 sys_clk = ~sys_clk;

  comparator_2bit #(.WIDTH(2), .SIGNED_CMP(0), .CNT_W(2)) dut_u (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov_u), .less(lt_u), .equal(eq_u), .greater(gt_u)
`ifdef COMPARATOR_STATS_EN
    , .stats_clr(stats_clr), .cnt_less(cl_u), .cnt_equal(ce_u), .cnt_greater(cg_u)
`endif
  );

  comparator_2bit #(.WIDTH(2), .SIGNED_CMP(1), .CNT_W(2)) dut_s (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov_s), .less(lt_s), .equal(eq_s), .greater(gt_s)
`ifdef COMPARATOR_STATS_EN
    , .stats_clr(stats_clr), .cnt_less(cl_s), .cnt_equal(ce_s), .cnt_greater(cg_s)
`endif
  );

  // Drive one cycle: set inputs, pass the rising edge, settle 1 time unit.
  task automatic cycle(input logic rst, input logic vld, input logic [1:0] av, input logic [1:0] bv);
    sys_rst  = rst;
    in_valid = vld;
    a        = av;
    b        = bv;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 2'd3, 2'd0);
      n_vec++;
      if ({ov_u, lt_u, eq_u, gt_u} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset[%0d]: got %b expected 0000", i, {ov_u, lt_u, eq_u, gt_u});
      end
    end
`ifdef COMPARATOR_STATS_EN
    n_vec++;
    if ({cl_u, ce_u, cg_u} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_cnt: got %b expected 000000", {cl_u, ce_u, cg_u});
    end
`endif
    cycle(1'b0, 1'b1, 2'd3, 2'd0);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 1001", {ov_u, lt_u, eq_u, gt_u});
    end
  endtask

  task automatic test_sweep();
    // {less, equal, greater} indexed by {a, b}
    logic [2:0] exp_tab [16] = '{
      3'b010, 3'b100, 3'b100, 3'b100,
      3'b001, 3'b010, 3'b100, 3'b100,
      3'b001, 3'b001, 3'b010, 3'b100,
      3'b001, 3'b001, 3'b001, 3'b010};
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx;
      idx = 4'(i);
      cycle(1'b0, 1'b1, idx[3:2], idx[1:0]);
      n_vec++;
      if ({ov_u, lt_u, eq_u, gt_u} !== {1'b1, exp_tab[i]}) begin
        n_err++;
        $display("FAIL sweep a=%0d b=%0d: got %b expected %b", idx[3:2], idx[1:0],
                 {ov_u, lt_u, eq_u, gt_u}, {1'b1, exp_tab[i]});
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b1, 2'd1, 2'd2);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b1100) begin
      n_err++;
      $display("FAIL hold_load: got %b expected 1100", {ov_u, lt_u, eq_u, gt_u});
    end
    cycle(1'b0, 1'b0, 2'd3, 2'd0);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b0100) begin
      n_err++;
      $display("FAIL hold_idle: got %b expected 0100", {ov_u, lt_u, eq_u, gt_u});
    end
    cycle(1'b0, 1'b0, 2'bxx, 2'bzz);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b0100) begin
      n_err++;
      $display("FAIL hold_xz: got %b expected 0100", {ov_u, lt_u, eq_u, gt_u});
    end
  endtask

  task automatic test_signed();
    logic [1:0] av [4] = '{2'b10, 2'b11, 2'b00, 2'b10};
    logic [1:0] bv [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [2:0] es [4] = '{3'b100, 3'b001, 3'b001, 3'b100};
    logic [2:0] eu [4] = '{3'b001, 3'b001, 3'b100, 3'b100};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, av[i], bv[i]);
      n_vec++;
      if ({ov_s, lt_s, eq_s, gt_s} !== {1'b1, es[i]}) begin
        n_err++;
        $display("FAIL signed[%0d]: got %b expected %b", i, {ov_s, lt_s, eq_s, gt_s}, {1'b1, es[i]});
      end
      n_vec++;
      if ({ov_u, lt_u, eq_u, gt_u} !== {1'b1, eu[i]}) begin
        n_err++;
        $display("FAIL unsigned_ref[%0d]: got %b expected %b", i, {ov_u, lt_u, eq_u, gt_u}, {1'b1, eu[i]});
      end
    end
  endtask

`ifdef COMPARATOR_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    cycle(1'b0, 1'b0, 2'd0, 2'd0);
    stats_clr = 1'b0;
    n_vec++;
    if ({cl_u, ce_u, cg_u} !== 6'b000000) begin
      n_err++;
      $display("FAIL stats_clr_idle: got %b expected 000000", {cl_u, ce_u, cg_u});
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd0, 2'd1);
    n_vec++;
    if ({cl_u, ce_u, cg_u} !== 6'b110000) begin
      n_err++;
      $display("FAIL stats_sat: got %b expected 110000", {cl_u, ce_u, cg_u});
    end
    stats_clr = 1'b1;
    cycle(1'b0, 1'b1, 2'd2, 2'd2);
    stats_clr = 1'b0;
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u, cl_u, ce_u, cg_u} !== 10'b1010_000000) begin
      n_err++;
      $display("FAIL stats_clr_valid: got %b expected 1010000000",
               {ov_u, lt_u, eq_u, gt_u, cl_u, ce_u, cg_u});
    end
    cycle(1'b0, 1'b1, 2'd3, 2'd1);
    n_vec++;
    if ({cl_u, ce_u, cg_u} !== 6'b000001) begin
      n_err++;
      $display("FAIL stats_count: got %b expected 000001", {cl_u, ce_u, cg_u});
    end
  endtask
`endif

  task automatic test_back_to_back_reset();
    cycle(1'b0, 1'b1, 2'd1, 2'd0);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b1001) begin
      n_err++;
      $display("FAIL b2b_pre: got %b expected 1001", {ov_u, lt_u, eq_u, gt_u});
    end
    cycle(1'b1, 1'b1, 2'd0, 2'd0);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b0000) begin
      n_err++;
      $display("FAIL b2b_rst: got %b expected 0000", {ov_u, lt_u, eq_u, gt_u});
    end
    cycle(1'b0, 1'b1, 2'd0, 2'd3);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b1100) begin
      n_err++;
      $display("FAIL b2b_resume0: got %b expected 1100", {ov_u, lt_u, eq_u, gt_u});
    end
    cycle(1'b0, 1'b1, 2'd3, 2'd3);
    n_vec++;
    if ({ov_u, lt_u, eq_u, gt_u} !== 4'b1010) begin
      n_err++;
      $display("FAIL b2b_resume1: got %b expected 1010", {ov_u, lt_u, eq_u, gt_u});
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sweep();
    test_hold();
    test_signed();
`ifdef COMPARATOR_STATS_EN
    test_stats();
`endif
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/comparator_2bit.md
Name: comparator_2bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 2 bits).
- Produces one-hot less/equal/greater flags one clock after a qualified input sample.
- Used as a leaf compare stage in small datapaths and teaching designs.
- Carries optional per-result event counters for bring-up and debug.

Parameters:
- WIDTH, 2, operand width in bits; legal range 1..16.
- SIGNED_CMP, 0, 0 = unsigned compare, 1 = two's-complement compare.
- CNT_W, 8, width of each optional event counter; legal range 2..32.

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- in_valid  in  1  qualifies a/b this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result flags valid this cycle.
- less  out  1  registered (a < b).
- equal  out  1  registered (a == b).
- greater  out  1  registered (a > b).
- stats_clr  in  1  synchronous clear of event counters (present only with the macro).
- cnt_less  out  CNT_W  count of less results (present only with the macro).
- cnt_equal  out  CNT_W  count of equal results (present only with the macro).
- cnt_greater  out  CNT_W  count of greater results (present only with the macro).

Behaviour:
- Reset, sampled on a sys_clk edge with sys_rst=1:
  - out_valid=0, less=0, equal=0, greater=0.
  - All counters = 0.
- Reset has priority over every other input.
- Latency is 1 cycle. If in_valid=1 at edge N, flags reflect that a/b pair after edge N, and out_valid=1 in the same cycle.
- When in_valid=0 at an edge:
  - out_valid goes to 0.
  - less/equal/greater hold their last values; they are not cleared.
- Exactly one of less/equal/greater is 1 whenever out_valid=1. After reset and before the first valid sample, all three flags are 0.
- Unsigned mode (SIGNED_CMP=0): operands are plain binary. For WIDTH=2, 3 > 2 > 1 > 0.
- Signed mode (SIGNED_CMP=1): operands are two's complement. For WIDTH=2, 2'b10 = -2 is less than 2'b11 = -1, which is less than 0.
- equal is a pure bitwise match and is independent of SIGNED_CMP.
- Back-to-back in_valid=1 is supported. Throughput is one compare per cycle; there is no backpressure.
- The datapath is purely combinational compare feeding a register. No state machine.
- X/Z on a or b while in_valid=0 must not affect the outputs.

Optional Feature:
- Macro: COMPARATOR_STATS_EN.
- With the macro defined:
  - The stats_clr, cnt_less, cnt_equal and cnt_greater ports exist.
  - Each valid sample increments exactly one counter, the one matching the result, on the same edge the flags register.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - stats_clr=1 zeroes all counters at the edge. If in_valid=1 in that same cycle, the sample is still compared and flagged, but it is not counted (clear wins).
  - sys_rst also zeroes all counters.
- Without the macro:
  - Those four ports and all counter logic are absent.
  - Compare behaviour is identical.

Test Plan:
- Reset: hold sys_rst=1 for 3 cycles with in_valid=1 and a=3, b=0 -> out_valid=0 and all flags 0 throughout; first flags appear 1 cycle after release.
- Exhaustive unsigned sweep, WIDTH=2: all 16 (a,b) pairs from 00/00 to 11/11, one per cycle with in_valid=1. Required flags 1 cycle later:
  - a=0: b=0 equal; b=1..3 less.
  - a=1: b=0 greater; b=1 equal; b=2..3 less.
  - a=2: b=0..1 greater; b=2 equal; b=3 less.
  - a=3: b=0..2 greater; b=3 equal.
  - out_valid=1 for 16 consecutive cycles.
- Hold: a=1, b=2 valid, then in_valid=0 with a=3, b=0 -> less stays 1, out_valid drops to 0.
- Signed, SIGNED_CMP=1, WIDTH=2:
  - a=2'b10, b=2'b01 -> less=1.
  - a=2'b11, b=2'b10 -> greater=1.
  - a=2'b00, b=2'b11 -> greater=1.
- Stats with COMPARATOR_STATS_EN and CNT_W=2:
  - 5 valid less samples -> cnt_less=3 (saturated); cnt_equal=0, cnt_greater=0.
  - Then stats_clr=1 with a valid equal sample -> equal=1, all counters 0.
- Reset mid-stream: assert sys_rst during a back-to-back valid burst -> the next cycle shows out_valid=0 and flags 0; the burst resumes correctly after release.
